// File: rtl/serial_sub_ctrl_pkg.sv
// Shared types and sizing helpers for the bit-serial subtraction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_sub_pkg;

   // Controller sequencing states; encodings are fixed so they read cleanly in waves.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Width of the bit counter: enough to hold WIDTH-1, never less than one bit.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a requester and the serial subtractor.
// Latency: n/a (wires only).
// Backpressure: busy tells the requester that start will be ignored.
interface serial_sub_ctrl_if #(
   parameter int WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   // Requester side drives operands and the start strobe.
   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
   );

   // Controller side consumes the request and returns the result.
   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
   );

endinterface

// File: rtl/serial_sub_ctrl_bit_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
// Latency: purely combinational.
// Backpressure: none.
module sub_bit_cell (
   input  logic x_i,
   input  logic y_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   // Borrow is generated when y exceeds x, or propagated when x equals y.
   always_comb begin
      d_o    = x_i ^ y_i ^ bin_i;
      bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
   end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: streams operands LSB-first through one sub_bit_cell.
// Latency: done pulses WIDTH+1 cycles after the accepted start; one op per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped, not queued.
module serial_sub_ctrl
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic               clk,
   input logic               rst_n,
   serial_sub_ctrl_if.slave  bus
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             cell_d;
   logic             cell_bout;

   // The single shared subtract cell always looks at the current LSBs and carried borrow.
   sub_bit_cell u_cell (
      .x_i    (a_sh_q[0]),
      .y_i    (b_sh_q[0]),
      .bin_i  (borrow_q),
      .d_o    (cell_d),
      .bout_o (cell_bout)
   );

   // Next-state, datapath shifting and result capture; everything holds by default.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      part_d   = part_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = RUN;
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               part_d   = '0;
               cnt_d    = '0;
               borrow_d = 1'b0;
            end
         end
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            part_d   = {cell_d, part_q[WIDTH-1:1]};
            borrow_d = cell_bout;
            if (cnt_q == LAST_BIT) begin
               // Last bit: publish the completed difference on the same edge.
               state_d = DONE;
               diff_d  = {cell_d, part_q[WIDTH-1:1]};
               bout_d  = cell_bout;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags follow the next state so they come straight from flops.
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and datapath registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         part_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         part_q   <= part_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Drive the result bundle from registers only.
   always_comb begin
      bus.busy       = busy_q;
      bus.done       = done_q;
      bus.diff       = diff_q;
      bus.borrow_out = bout_q;
   end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed corner cases plus a random back-to-back stream.
// Latency: expects done WIDTH edges after the accepting edge, idle one edge later.
// Backpressure: exercises starts issued while busy, which must be ignored.
module tb_serial_sub_ctrl;

   localparam int W    = 8;
   localparam int PER  = W + 2;
   localparam int NOPS = 1000;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   int   exp_d_q[$];
   int   exp_b_q[$];

   serial_sub_ctrl_if #(.WIDTH(W)) bus ();

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: unsigned difference modulo 2^W, borrow when minuend is smaller.
   function automatic int ref_diff(input int x, input int y);
      int r;
      r = x - y;
      if (r < 0) r = r + (1 << W);
      return r;
   endfunction

   function automatic int ref_borrow(input int x, input int y);
      return (x < y) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One operation with full timing checks; optionally fires stray starts at T+3 and in DONE.
   task automatic do_op(input int oa, input int ob, input bit inject);
      int ed;
      int eb;
      int dones;
      ed    = ref_diff(oa, ob);
      eb    = ref_borrow(oa, ob);
      dones = 0;
      check("idle_before_start", 32'(bus.busy), 32'd0);
      bus.a     = W'(oa);
      bus.b     = W'(ob);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n <= W + 1; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         check("busy_window", 32'(bus.busy), (n <= W) ? 32'd1 : 32'd0);
         check("done_window", 32'(bus.done), (n == W) ? 32'd1 : 32'd0);
         if (bus.done === 1'b1) dones++;
         if (n >= W) begin
            check("diff", 32'(bus.diff), 32'(ed));
            check("borrow_out", 32'(bus.borrow_out), 32'(eb));
         end
         bus.start = (inject && (n == 2 || n == W)) ? 1'b1 : 1'b0;
         bus.a     = W'($urandom);
         bus.b     = W'($urandom);
      end
      bus.start = 1'b0;
      check("single_done_pulse", 32'(dones), 32'd1);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_borrow", 32'(bus.borrow_out), 32'd0);
      rst_n = 1'b1;

      // Directed operand patterns
      do_op(200, 55, 1'b1);
      do_op(5, 10, 1'b0);
      do_op(0, 0, 1'b0);
      do_op(255, 255, 1'b0);
      do_op(0, 1, 1'b0);

      // Reset in the middle of RUN discards the operation
      bus.a     = W'(77);
      bus.b     = W'(100);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      check("midrst_diff", 32'(bus.diff), 32'd0);
      check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
      for (int i = 0; i < PER + 2; i++) begin
         @(posedge clk);
         #1;
         check("midrst_no_done", 32'(bus.done), 32'd0);
         check("midrst_stays_idle", 32'(bus.busy), 32'd0);
      end
      do_op(130, 17, 1'b0);

      // Start held high with operands changing every cycle; accepts land every PER edges
      bus.start = 1'b1;
      for (int c = 0; c < NOPS * PER; c++) begin
         bus.a = W'($urandom);
         bus.b = W'($urandom);
         if (c % PER == 0) begin
            exp_d_q.push_back(ref_diff(int'(bus.a), int'(bus.b)));
            exp_b_q.push_back(ref_borrow(int'(bus.a), int'(bus.b)));
         end
         @(posedge clk);
         #1;
         check("stream_done", 32'(bus.done), (c % PER == W) ? 32'd1 : 32'd0);
         if (c % PER == W) begin
            if (exp_d_q.size() == 0) begin
               check("stream_model_underflow", 32'd1, 32'd0);
            end else begin
               check("stream_diff", 32'(bus.diff), 32'(exp_d_q.pop_front()));
               check("stream_borrow", 32'(bus.borrow_out), 32'(exp_b_q.pop_front()));
            end
         end
      end
      bus.start = 1'b0;
      check("stream_all_completed", 32'(exp_d_q.size()), 32'd0);
      @(posedge clk);
      #1;
      check("stream_end_idle", 32'(bus.busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
